pwm_dec: RTL and testbench

PWM_DEC -- requirements
Module: pwm_dec

---
 rtl/pwm_dec_pkg.sv | 12 +
 rtl/pwm_hi_cnt.sv | 50 +++++
 rtl/pwm_dec.sv | 123 ++++++++++++
 tb/tb_pwm_dec.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dec_pkg.sv
// Shared constants and FSM state type for the 11-bit PWM driver and its decoder.
package pwm_dec_pkg;

  localparam int unsigned PWM_PER_W = 11;
  localparam int unsigned SPD_W     = 12;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/pwm_hi_cnt.sv
// Input synchronizer plus saturating high-time counter with a window restart.
module pwm_hi_cnt #(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm,
  input  logic             restart,
  output logic             sync,
  output logic [CNT_W-1:0] total
);

  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};

  logic [SYNC_STG-1:0] sr;
  logic [CNT_W-1:0]    h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= pwm;
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign sync = sr[SYNC_STG-1];

  // total already includes the current cycle so the terminal-count evaluation sees it
  always_comb begin
    total = h;
    if (sync && (h != CNT_MAX)) begin
      total = h + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
    end else if (restart) begin
      h <= '0;
    end else begin
      h <= total;
    end
  end

endmodule

// File: rtl/pwm_dec.sv
// Recovers signed speed from forward/reverse H-bridge PWM lines over free-running windows.
module pwm_dec
  import pwm_dec_pkg::*;
#(
  parameter int unsigned PER_W    = PWM_PER_W,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PWM1,
  input  logic             PWM2,
  input  logic             clr_err,
  output logic [SPD_W-1:0] spd,
  output logic             spd_vld,
  output logic             dir_err,
  output logic             shoot
);

  logic [PER_W-1:0] win;
  logic             tc;
  logic             s1, s2;
  logic [PER_W:0]   t1, t2;

  dec_state_t       state, state_nxt;
  logic [SPD_W-1:0] spd_nxt;
  logic             vld_nxt, err_nxt, shoot_nxt;

  assign tc = (win == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else begin
      win <= win + PER_W'(1);
    end
  end

  pwm_hi_cnt #(
    .SYNC_STG (SYNC_STG),
    .CNT_W    (PER_W + 1)
  ) u_cnt1 (
    .clk     (clk),
    .rst     (rst),
    .pwm     (PWM1),
    .restart (tc),
    .sync    (s1),
    .total   (t1)
  );

  pwm_hi_cnt #(
    .SYNC_STG (SYNC_STG),
    .CNT_W    (PER_W + 1)
  ) u_cnt2 (
    .clk     (clk),
    .rst     (rst),
    .pwm     (PWM2),
    .restart (tc),
    .sync    (s2),
    .total   (t2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    spd_nxt   = spd;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      FILL: begin
        if (tc) state_nxt = RUN;
      end
      RUN: begin
        if (tc) begin
          // reverse magnitude is one's-complemented to undo the driver's encoding
          if ((t1 != '0) && (t2 != '0)) begin
            err_nxt = 1'b1;
          end else if (t1 != '0) begin
            spd_nxt = {1'b0, t1[PER_W-1:0]};
            vld_nxt = 1'b1;
          end else if (t2 != '0) begin
            spd_nxt = {1'b1, ~t2[PER_W-1:0]};
            vld_nxt = 1'b1;
          end else begin
            spd_nxt = '0;
            vld_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    shoot_nxt = shoot;
    if (s1 && s2) begin
      shoot_nxt = 1'b1;
    end else if (clr_err) begin
      shoot_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd     <= '0;
      spd_vld <= 1'b0;
      dir_err <= 1'b0;
      shoot   <= 1'b0;
    end else begin
      spd     <= spd_nxt;
      spd_vld <= vld_nxt;
      dir_err <= err_nxt;
      shoot   <= shoot_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_dec.sv
// Scoreboarded bench: stimulus queues per-window expectations, a monitor pops them on each output event.
module tb_pwm_dec;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        PWM1    = 1'b0;
  logic        PWM2    = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] spd;
  logic        spd_vld;
  logic        dir_err;
  logic        shoot;

  pwm_dec #(
    .PER_W    (11),
    .SYNC_STG (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .PWM1    (PWM1),
    .PWM2    (PWM2),
    .clr_err (clr_err),
    .spd     (spd),
    .spd_vld (spd_vld),
    .dir_err (dir_err),
    .shoot   (shoot)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [11:0] spd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stimulus state: window j-index, per-line duty/phase over a 2048-clock period
  int          j = 0;
  int          d1 = 0, ph1 = 0, d2 = 0, ph2 = 0;
  bit          ovr = 1'b0;
  int unsigned rel_cyc = 0;
  int unsigned rst_epoch = 0;

  function automatic bit pat(input int d, input int ph, input int jj);
    return ((jj + ph) % 2048) < d;
  endfunction

  task automatic drive();
    PWM1 = ovr | pat(d1, ph1, j);
    PWM2 = ovr | pat(d2, ph2, j);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    j++;
    drive();
  endtask

  task automatic run_to(input int t);
    while (j < t) step();
  endtask

  task automatic seg(input int a1, input int p1, input int a2, input int p2,
                     input int n, input bit err, input logic [11:0] s);
    exp_t e;
    d1 = a1; ph1 = p1; d2 = a2; ph2 = p2;
    drive();
    e.err = err;
    e.spd = s;
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    j = 0;
    rel_cyc = cyc;
    rst_epoch++;
  endtask

  // Monitor
  exp_t        mon_e;
  int unsigned seen_epoch = 0;
  int unsigned last_evt = 0;

  always @(negedge clk) begin
    if (!rst && (spd_vld || dir_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: actual vld=%0b err=%0b spd=0x%0h required none (t=%0t)",
                 spd_vld, dir_err, spd, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_dir_err", dir_err, mon_e.err);
        check("evt_spd_vld", spd_vld, !mon_e.err);
        check("evt_spd", spd, mon_e.spd);
      end
      if (seen_epoch != rst_epoch) begin
        check("first_event_latency", cyc - rel_cyc, 4096);
        seen_epoch = rst_epoch;
      end else begin
        check("event_spacing", cyc - last_evt, 2048);
      end
      last_evt = cyc;
    end
  end

  initial begin
    PWM1 = 1'b1;
    PWM2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_spd", spd, 0);
    check("rst_spd_vld", spd_vld, 0);
    check("rst_dir_err", dir_err, 0);
    check("rst_shoot", shoot, 0);

    release_rst();
    seg(12'h200, 12'h123, 0, 0, 3, 1'b0, 12'h200);       // windows 0..3, window 0 is FILL
    run_to(4 * 2048 - 2);
    seg(0, 0, 12'h5FF, 12'h7A0, 2, 1'b0, 12'hA00);
    run_to(6 * 2048 - 2);
    seg(0, 0, 0, 0, 1, 1'b0, 12'h000);
    run_to(7 * 2048 - 2);
    seg(2048, 0, 0, 0, 2, 1'b0, 12'h7FF);
    run_to(9 * 2048 - 2);
    seg(12'h100, 0, 12'h100, 12'h400, 1, 1'b1, 12'h7FF);
    run_to(10 * 2048 - 2);
    check("no_shoot_nonoverlap", shoot, 0);

    seg(0, 0, 0, 0, 1, 1'b1, 12'h7FF);
    run_to(10 * 2048 - 2 + 100);
    ovr = 1'b1;
    drive();
    step();
    step();
    ovr = 1'b0;
    step();
    repeat (5) step();
    check("shoot_set", shoot, 1);
    repeat (50) step();
    check("shoot_sticky", shoot, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("shoot_clr", shoot, 0);
    repeat (10) step();
    ovr = 1'b1;
    drive();
    step();
    ovr = 1'b0;
    drive();
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("shoot_set_wins", shoot, 1);
    repeat (5) step();
    check("shoot_hold_after_race", shoot, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("shoot_clr2", shoot, 0);
    run_to(11 * 2048 - 2);

    seg(12'h200, 12'h321, 0, 0, 2, 1'b0, 12'h200);
    run_to(13 * 2048 + 1000);
    check("spd_before_rst", spd, 12'h200);
    rst = 1'b1;
    #1;
    check("midrst_spd", spd, 0);
    check("midrst_spd_vld", spd_vld, 0);
    check("midrst_shoot", shoot, 0);
    repeat (2) @(posedge clk);
    release_rst();
    seg(12'h200, 12'h321, 0, 0, 2, 1'b0, 12'h200);
    run_to(3 * 2048 + 10);

    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending events required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
